// File: rtl/sm_add_pkg.sv
// sm_add_pkg: shared types, widths and helpers for the sign-magnitude adder arbiter.
//   SM_WIDTH  default operand width (sign bit + magnitude)
//   ID_W      width of the requester id tag
//   sm_word_t sign-magnitude word layout at the default width
//   sm_norm   returns the normalised sign bit (a zero magnitude is always +0)
package sm_add_pkg;

    localparam int unsigned SM_WIDTH = 4;
    localparam int unsigned ID_W     = 1;

    typedef struct packed {
        logic                  sign;
        logic [SM_WIDTH-2:0]   mag;
    } sm_word_t;

    // Forces the sign of a zero-magnitude result to positive so -0 never leaves the block.
    function automatic logic sm_norm(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/signed_mag_adder.sv
// signed_mag_adder: combinational sign-magnitude adder.
//   i_a, i_b    WIDTH  operands, [WIDTH-1]=sign, [WIDTH-2:0]=magnitude
//   o_sum_c     WIDTH  sum, magnitude truncated on carry-out; -0 is not normalised here
//   o_carry_c   1      magnitude carry-out of a same-sign add (0 for opposite signs)
module signed_mag_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum_c,
    output logic             o_carry_c
);

    localparam int unsigned MAG_W = WIDTH - 1;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic [MAG_W:0]   w_add;
    logic [MAG_W-1:0] w_sub_ab;
    logic [MAG_W-1:0] w_sub_ba;
    logic             w_a_ge_b;

    assign w_sign_a = i_a[WIDTH-1];
    assign w_sign_b = i_b[WIDTH-1];
    assign w_mag_a  = i_a[MAG_W-1:0];
    assign w_mag_b  = i_b[MAG_W-1:0];
    assign w_add    = {1'b0, w_mag_a} + {1'b0, w_mag_b};
    assign w_sub_ab = w_mag_a - w_mag_b;
    assign w_sub_ba = w_mag_b - w_mag_a;
    assign w_a_ge_b = (w_mag_a >= w_mag_b);

    // Same signs add magnitudes; opposite signs subtract the smaller from the larger.
    always_comb begin
        o_sum_c   = '0;
        o_carry_c = 1'b0;
        if (w_sign_a == w_sign_b) begin
            o_sum_c   = {w_sign_a, w_add[MAG_W-1:0]};
            o_carry_c = w_add[MAG_W];
        end else if (w_a_ge_b) begin
            o_sum_c = {w_sign_a, w_sub_ab};
        end else begin
            o_sum_c = {w_sign_b, w_sub_ba};
        end
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter: two requesters share one sign-magnitude adder through a round-robin
// arbiter; the winner's sum is registered with its id, an overflow flag and -0 removed.
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_reqK_valid / o_reqK_ready (K=0,1)     operand pair handshake
//   i_reqK_a, i_reqK_b                      WIDTH-bit sign-magnitude operands
//   o_valid / i_ready                       result handshake
//   o_sum, o_id, o_ovf                      registered sum, requester id, overflow flag
module sm_add_arbiter
    import sm_add_pkg::*;
#(
    parameter int unsigned WIDTH = SM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_id,
    output logic             o_ovf
);

    localparam int unsigned MAG_W = WIDTH - 1;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic [ID_W-1:0]  r_id;
    logic             r_ovf;
    logic [ID_W-1:0]  r_rr_ptr;

    logic [ID_W-1:0]  w_grant_id;
    logic             w_sel1;
    logic             w_any_valid;
    logic             w_can_accept;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_carry;
    logic             w_ovf;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;

    // Reset asserts asynchronously and releases two clocks later, in step with i_clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Round-robin grant: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        w_grant_id = ID_W'(0);
        if (i_req0_valid && i_req1_valid) begin
            w_grant_id = r_rr_ptr;
        end else if (i_req1_valid) begin
            w_grant_id = ID_W'(1);
        end
    end

    assign w_sel1       = (w_grant_id == ID_W'(1));
    assign w_any_valid  = i_req0_valid | i_req1_valid;
    assign w_can_accept = ~r_valid | i_ready;
    assign w_accept     = w_rst_n & w_can_accept & w_any_valid;
    assign o_req0_ready = w_accept & ~w_sel1;
    assign o_req1_ready = w_accept & w_sel1;

    assign w_op_a = w_sel1 ? i_req1_a : i_req0_a;
    assign w_op_b = w_sel1 ? i_req1_b : i_req0_b;

    signed_mag_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_sum_c   (w_add_sum),
        .o_carry_c (w_add_carry)
    );

    // Overflow only exists for same-sign adds; the truncated magnitude is kept.
    assign w_ovf  = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) & w_add_carry;
    assign w_mag  = w_add_sum[MAG_W-1:0];
    assign w_sign = sm_norm(w_add_sum[WIDTH-1], (w_mag == '0));

    // Result slot and round-robin pointer; the pointer only moves on an accepted pair.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_valid  <= 1'b0;
            r_sum    <= '0;
            r_id     <= '0;
            r_ovf    <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_sum    <= {w_sign, w_mag};
            r_id     <= w_grant_id;
            r_ovf    <= w_ovf;
            r_rr_ptr <= ~w_grant_id;
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_id    = r_id;
    assign o_ovf   = r_ovf;

endmodule
